// File: rtl/pipelined_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_alu_mc
//  Purpose  : Multi-cycle RV64I-style ALU with iterative MUL/DIVU/REMU and
//             valid/ready handshakes on both the operand and result sides.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_alu_mc #(
    parameter int WIDTH         = 64,
    parameter int SHW           = $clog2(WIDTH),
    parameter int TAG_W         = 4,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;
    localparam logic [3:0] c_OP_DIVU = 4'd11;
    localparam logic [3:0] c_OP_REMU = 4'd12;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_overflow;
    logic               r_illegal;
    logic [TAG_W-1:0]   r_out_tag;

    assign in_ready  = (r_state == c_ST_IDLE) || ((r_state == c_ST_DONE) && out_ready);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;
    assign out_tag   = r_out_tag;

    logic             w_accept;
    logic             w_is_sub;
    logic             w_is_addsub;
    logic [WIDTH-1:0] w_b_add;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sra;
    logic             w_muldiv_op;
    logic             w_illegal;
    logic             w_div_by_zero;
    logic             w_start_iter;
    logic [WIDTH-1:0] w_single;

    assign w_accept    = in_valid && in_ready;
    assign w_is_sub    = (op == c_OP_SUB) || (op == c_OP_SLT) || (op == c_OP_SLTU);
    assign w_is_addsub = (op == c_OP_ADD) || (op == c_OP_SUB);
    assign w_b_add     = w_is_sub ? ~b : b;
    assign {w_cout, w_sum} = {1'b0, a} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, w_is_sub};
    // Overflow judged on the second adder operand, so SUB/SLT use ~b here.
    assign w_ovf       = (a[WIDTH-1] == w_b_add[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_shamt     = b[SHW-1:0];
    assign w_sra       = $signed(a) >>> w_shamt;

    assign w_muldiv_op   = (ENABLE_MULDIV != 0) && (op >= c_OP_MUL) && (op <= c_OP_REMU);
    assign w_illegal     = (op > c_OP_REMU) ||
                           ((ENABLE_MULDIV == 0) && (op >= c_OP_MUL));
    assign w_div_by_zero = w_muldiv_op && (op != c_OP_MUL) && (b == '0);
    assign w_start_iter  = w_muldiv_op && !w_div_by_zero;

    always_comb begin
        w_single = '0;
        if (!w_illegal) begin
            case (op)
                c_OP_ADD, c_OP_SUB: w_single = w_sum;
                c_OP_AND:  w_single = a & b;
                c_OP_OR:   w_single = a | b;
                c_OP_XOR:  w_single = a ^ b;
                c_OP_SLL:  w_single = a << w_shamt;
                c_OP_SRL:  w_single = a >> w_shamt;
                c_OP_SRA:  w_single = w_sra;
                c_OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
                c_OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, ~w_cout};
                c_OP_DIVU: w_single = '1;
                c_OP_REMU: w_single = a;
                default:   w_single = '0;
            endcase
        end
    end

    // One iteration step: MUL keeps r_acc=partial product, r_x=shifted
    // multiplicand, r_y=remaining multiplier; DIV keeps r_acc=partial
    // remainder, r_x=divisor, r_y=dividend bits shifting into quotient bits.
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_iter_res;

    assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
    assign w_trial   = {r_acc, r_y[WIDTH-1]} - {1'b0, r_x};
    assign w_div_rem = w_trial[WIDTH] ? {r_acc[WIDTH-2:0], r_y[WIDTH-1]} : w_trial[WIDTH-1:0];
    assign w_div_quo = {r_y[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_iter_res = (r_op == c_OP_MUL)  ? w_mul_acc :
                        (r_op == c_OP_DIVU) ? w_div_quo : w_div_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_count     <= '0;
            r_op        <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            case (r_state)
                c_ST_BUSY: begin
                    if (r_op == c_OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_x   <= r_x << 1;
                        r_y   <= r_y >> 1;
                    end else begin
                        r_acc <= w_div_rem;
                        r_y   <= w_div_quo;
                    end
                    r_count <= r_count - c_CNT_W'(1);
                    if (r_count == '0) begin
                        r_state     <= c_ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_iter_res;
                        r_zero      <= (w_iter_res == '0);
                        r_carry     <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_illegal   <= 1'b0;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_out_tag <= in_tag;
                        if (w_start_iter) begin
                            r_state     <= c_ST_BUSY;
                            r_count     <= c_CNT_W'(WIDTH-1);
                            r_out_valid <= 1'b0;
                            r_op        <= op;
                            r_acc       <= '0;
                            r_x         <= (op == c_OP_MUL) ? a : b;
                            r_y         <= (op == c_OP_MUL) ? b : a;
                        end else begin
                            r_state     <= c_ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_single;
                            r_zero      <= (w_single == '0);
                            r_carry     <= w_is_addsub && w_cout;
                            r_overflow  <= w_is_addsub && w_ovf;
                            r_illegal   <= w_illegal;
                        end
                    end else if ((r_state == c_ST_DONE) && out_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_alu_mc
//  Purpose  : Self-checking bench: arithmetic reference model + scoreboard,
//             plus directed vectors with hand-computed results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        t_in_valid;
    logic        t_in_ready;
    logic [3:0]  t_op;
    logic [63:0] t_a;
    logic [63:0] t_b;
    logic [3:0]  t_in_tag;
    logic        t_out_valid;
    logic        t_out_ready;
    logic [63:0] t_result;
    logic        t_zero, t_carry, t_overflow, t_illegal;
    logic [3:0]  t_out_tag;

    logic        s_in_valid, s_in_ready, s_out_valid;
    logic [3:0]  s_op;
    logic [31:0] s_a, s_b, s_result;
    logic        s_zero, s_carry, s_overflow, s_illegal;
    logic [3:0]  s_out_tag;

    pipelined_alu_mc #(.WIDTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid), .in_ready(t_in_ready),
        .op(t_op), .a(t_a), .b(t_b), .in_tag(t_in_tag),
        .out_valid(t_out_valid), .out_ready(t_out_ready),
        .result(t_result), .zero(t_zero), .carry(t_carry),
        .overflow(t_overflow), .illegal(t_illegal), .out_tag(t_out_tag)
    );

    pipelined_alu_mc #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .b(s_b), .in_tag(4'd0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .result(s_result), .zero(s_zero), .carry(s_carry),
        .overflow(s_overflow), .illegal(s_illegal), .out_tag(s_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct packed {
        logic [63:0] res;
        logic        z, c, v, il;
    } exp_t;

    typedef struct {
        exp_t       e;
        logic [3:0] tag;
        int         due;
    } ent_t;

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t               e;
        logic [64:0]        u;
        logic signed [65:0] s;
        logic signed [63:0] sa;
        e  = '0;
        sa = a;
        s  = '0;
        case (op)
            4'd0: begin
                u = {1'b0, a} + {1'b0, b};
                e.res = u[63:0];
                e.c   = u[64];
                s     = $signed({a[63], a[63], a}) + $signed({b[63], b[63], b});
                e.v   = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
            end
            4'd1: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = $signed({a[63], a[63], a}) - $signed({b[63], b[63], b});
                e.v   = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = a << b[5:0];
            4'd6:  e.res = a >> b[5:0];
            4'd7:  e.res = sa >>> b[5:0];
            4'd8:  e.res = {63'd0, ($signed(a) < $signed(b))};
            4'd9:  e.res = {63'd0, (a < b)};
            4'd10: e.res = a * b;
            4'd11: e.res = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            4'd12: e.res = (b == 0) ? a : a % b;
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [63:0] b);
        return (op == 4'd10 || ((op == 4'd11 || op == 4'd12) && b != 0)) ? 65 : 1;
    endfunction

    // Scoreboard compare, every falling edge.
    ent_t q[$];
    ent_t h;
    ent_t ne;
    logic exp_v;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", {63'd0, t_out_valid}, 64'd0);
            chk("rst_result", t_result, 64'd0);
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].due);
            chk("out_valid", {63'd0, t_out_valid}, {63'd0, exp_v});
            chk("in_ready", {63'd0, t_in_ready},
                {63'd0, (q.size() == 0) ? 1'b1 : (exp_v ? t_out_ready : 1'b0)});
            if (exp_v) begin
                h = q[0];
                chk("sb_result", t_result, h.e.res);
                chk("sb_flags", {60'd0, t_zero, t_carry, t_overflow, t_illegal},
                    {60'd0, h.e.z, h.e.c, h.e.v, h.e.il});
                chk("sb_tag", {60'd0, t_out_tag}, {60'd0, h.tag});
                if (t_out_ready) void'(q.pop_front());
            end
            if (t_in_valid && t_in_ready) begin
                ne.e   = model(t_op, t_a, t_b);
                ne.tag = t_in_tag;
                ne.due = cyc + latency(t_op, t_b);
                q.push_back(ne);
            end
        end
    end

    logic [3:0] tag_ctr = 4'd0;

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, output int t0);
        int n;
        t_op = op; t_a = a; t_b = b; t_in_tag = tag; t_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!t_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!t_in_ready) chk("issue_timeout", 64'd0, 64'd1);
        t0 = cyc;
        @(posedge clk) #1;
        t_in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input logic [3:0] exp_flags, input int exp_lat);
        int t0;
        issue(op, a, b, tag_ctr, t0);
        tag_ctr = tag_ctr + 4'd1;
        do @(negedge clk); while (!t_out_valid && (cyc - t0) < 200);
        chk({nm, "_res"}, t_result, exp_res);
        chk({nm, "_flags"}, {60'd0, t_zero, t_carry, t_overflow, t_illegal}, {60'd0, exp_flags});
        chk({nm, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int t0;
        rst_n = 1'b1;
        t_in_valid = 1'b0; t_op = 4'd0; t_a = '0; t_b = '0; t_in_tag = '0;
        t_out_ready = 1'b1;
        s_in_valid = 1'b0; s_op = 4'd0; s_a = '0; s_b = '0;

        // Pin the reference model to hand-computed values.
        chk("pin_add",  model(4'd0, MAXP, 64'd1).res, MINN);
        chk("pin_addv", {63'd0, model(4'd0, MAXP, 64'd1).v}, 64'd1);
        chk("pin_slt",  model(4'd8, MINN, 64'd1).res, 64'd1);
        chk("pin_sra",  model(4'd7, MINN, 64'd63).res, ONES);
        chk("pin_mul",  model(4'd10, ONES, 64'd3).res, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_rem",  model(4'd12, 64'd100, 64'd7).res, 64'd2);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        //       name      op     a                      b                      result                 {z,c,v,il} lat
        run_op("add_ovf",  4'd0,  MAXP,                  64'd1,                 MINN,                  4'b0010,  1);
        run_op("sub_eq",   4'd1,  64'd5,                 64'd5,                 64'd0,                 4'b1100,  1);
        run_op("sub_ovf",  4'd1,  MINN,                  64'd1,                 MAXP,                  4'b0110,  1);
        run_op("slt_neg",  4'd8,  MINN,                  64'd1,                 64'd1,                 4'b0000,  1);
        run_op("sltu",     4'd9,  MINN,                  64'd1,                 64'd0,                 4'b1000,  1);
        run_op("slt_pos",  4'd8,  MAXP,                  ONES,                  64'd0,                 4'b1000,  1);
        run_op("sra63",    4'd7,  MINN,                  64'd63,                ONES,                  4'b0000,  1);
        run_op("srl63",    4'd6,  MINN,                  64'd63,                64'd1,                 4'b0000,  1);
        run_op("sll_wrap", 4'd5,  64'd1,                 64'h41,                64'd2,                 4'b0000,  1);
        run_op("xor",      4'd4,  64'hF0F0,              64'h0FF0,              64'hFF00,              4'b0000,  1);
        run_op("mul_neg",  4'd10, ONES,                  64'd3,                 64'hFFFF_FFFF_FFFF_FFFD, 4'b0000, 65);
        run_op("mul_pos",  4'd10, 64'h1234,              64'h5678,              64'h626_0060,          4'b0000, 65);
        run_op("divu",     4'd11, 64'd100,               64'd7,                 64'd14,                4'b0000, 65);
        run_op("remu",     4'd12, 64'd100,               64'd7,                 64'd2,                 4'b0000, 65);
        run_op("divu_big", 4'd11, ONES,                  64'h10,                64'h0FFF_FFFF_FFFF_FFFF, 4'b0000, 65);
        run_op("remu_big", 4'd12, 64'h1234_5678_90AB_CDEF, 64'h1000,            64'hDEF,               4'b0000, 65);
        run_op("divu_z",   4'd11, 64'd12345,             64'd0,                 ONES,                  4'b0000,  1);
        run_op("remu_z",   4'd12, 64'd9,                 64'd0,                 64'd9,                 4'b0000,  1);

        // Stall the consumer, then stream four ADDs behind the held result.
        t_out_ready = 1'b0;
        issue(4'd0, 64'd10, 64'd20, 4'd5, t0);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, t_out_valid}, 64'd1);
            chk("hold_result", t_result, 64'd30);
            chk("hold_tag", {60'd0, t_out_tag}, 64'd5);
        end
        @(posedge clk) #1;
        t_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t_op = 4'd0; t_a = 64'(k * 100); t_b = 64'(k); t_in_tag = 4'(8 + k);
            t_in_valid = 1'b1;
            @(negedge clk);
            chk("b2b_ready", {63'd0, t_in_ready}, 64'd1);
            chk("b2b_tag", {60'd0, t_out_tag}, (k == 0) ? 64'd5 : 64'(7 + k));
            @(posedge clk) #1;
        end
        t_in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_tag", {60'd0, t_out_tag}, 64'd11);
        chk("b2b_last_res", t_result, 64'd303);
        @(posedge clk) #1;

        // 32-bit build: arithmetic shift fills from bit 31.
        s_op = 4'd7; s_a = 32'h8000_0000; s_b = 32'd31; s_in_valid = 1'b1;
        @(negedge clk);
        chk("w32_ready", {63'd0, s_in_ready}, 64'd1);
        @(posedge clk) #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        chk("w32_valid", {63'd0, s_out_valid}, 64'd1);
        chk("w32_sra", {32'd0, s_result}, 64'hFFFF_FFFF);
        @(posedge clk) #1;

        // Reset in the middle of a multiply.
        issue(4'd10, 64'd7, 64'd9, 4'd3, t0);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, t_out_valid}, 64'd0);
        chk("rst_mid_result", t_result, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("add_after", 4'd0, 64'd2, 64'd3, 64'd5, 4'b0000, 1);
        run_op("illegal",   4'd14, 64'd77, 64'd88, 64'd0, 4'b1001, 1);

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
